// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts word-aligned fetch requests, reads the
// word array and returns instructions in order through a credit-limited response FIFO.
module imem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          LATENCY     = 2,
   parameter int          RSP_DEPTH   = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [31:0]                    req_addr,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [31:0]                    rsp_inst,
   output logic                           rsp_fault,
   input  logic                           wr_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
   input  logic [31:0]                    wr_data
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [32:0]      ADDR_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

   logic             ready_reg;
   logic             accept;
   logic             pop;
   logic             req_fault;
   logic [IDX_W-1:0] req_idx;
   logic [CNT_W-1:0] outstanding_reg;
   logic [CNT_W-1:0] outstanding_next;

   logic             push_valid;
   logic             push_fault;
   logic [31:0]      push_data;

   logic [31:0]          mem [DEPTH_WORDS];
   logic [31:0]          fifo_data_reg [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] fifo_fault_reg;
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [CNT_W-1:0]     fifo_count_reg;
   logic [CNT_W-1:0]     fifo_count_next;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // BASE_ADDR is aligned to the array size, so the low address bits are the word index.
   assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                      ({1'b0, req_addr} >= ADDR_END);
   assign req_idx   = req_addr[IDX_W+1:2];

   assign req_ready = ready_reg & ~RST;
   assign accept    = req_valid & req_ready;
   assign rsp_valid = (fifo_count_reg != '0) & ~RST;
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_inst  = rsp_valid ? fifo_data_reg[rd_ptr_reg] : 32'h0000_0000;
   assign rsp_fault = rsp_valid & fifo_fault_reg[rd_ptr_reg];

   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   generate
      if (LATENCY == 1) begin : g_no_stages
         assign push_valid = accept;
         assign push_fault = req_fault;
         assign push_data  = req_fault ? 32'h0000_0000 : mem[req_idx];
      end else begin : g_stages
         localparam int STAGES = LATENCY - 1;

         logic [STAGES-1:0] stg_valid_reg;
         logic [STAGES-1:0] stg_fault_reg;
         logic [31:0]       stg_data_reg [STAGES];

         // Stage 0 is the registered array read; a write in the same cycle is not visible.
         always_ff @(posedge CLK) begin
            if (RST) begin
               stg_valid_reg[0] <= 1'b0;
            end else begin
               stg_valid_reg[0] <= accept;
            end
            if (accept) begin
               stg_fault_reg[0] <= req_fault;
               stg_data_reg[0]  <= req_fault ? 32'h0000_0000 : mem[req_idx];
            end
         end

         for (genvar gi = 1; gi < STAGES; gi++) begin : g_shift
            always_ff @(posedge CLK) begin
               if (RST) begin
                  stg_valid_reg[gi] <= 1'b0;
               end else begin
                  stg_valid_reg[gi] <= stg_valid_reg[gi-1];
               end
               stg_fault_reg[gi] <= stg_fault_reg[gi-1];
               stg_data_reg[gi]  <= stg_data_reg[gi-1];
            end
         end

         assign push_valid = stg_valid_reg[STAGES-1];
         assign push_fault = stg_fault_reg[STAGES-1];
         assign push_data  = stg_data_reg[STAGES-1];
      end
   endgenerate

   always_comb begin
      outstanding_next = outstanding_reg;
      if (accept && !pop) begin
         outstanding_next = outstanding_reg + CNT_W'(1);
      end else if (pop && !accept) begin
         outstanding_next = outstanding_reg - CNT_W'(1);
      end
   end

   // Ready is registered from the next credit count, so it never sees rsp_ready or req_valid combinationally.
   always_ff @(posedge CLK) begin
      if (RST) begin
         outstanding_reg <= '0;
         ready_reg       <= 1'b1;
      end else begin
         outstanding_reg <= outstanding_next;
         ready_reg       <= (outstanding_next < CNT_FULL);
      end
   end

   always_comb begin
      fifo_count_next = fifo_count_reg;
      if (push_valid && !pop) begin
         fifo_count_next = fifo_count_reg + CNT_W'(1);
      end else if (pop && !push_valid) begin
         fifo_count_next = fifo_count_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
      end else begin
         if (push_valid) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         fifo_count_reg <= fifo_count_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_valid) begin
         fifo_data_reg[wr_ptr_reg]  <= push_data;
         fifo_fault_reg[wr_ptr_reg] <= push_fault;
      end
   end

   // The credit count guarantees a free slot for every word that reaches the FIFO.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (!(push_valid && !pop && (fifo_count_reg == CNT_FULL)));
         assert (outstanding_reg <= CNT_FULL);
      end
   end

endmodule
